// File: rtl/xbar_w_buffer.sv
// W-channel beat buffer: DEPTH-entry circular FIFO with occupancy, almost-full and burst counters.
// Optional store-and-forward release is enabled by defining XBAR_W_STORE_FWD_EN.
module xbar_w_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [DATA_WIDTH-1:0]        s_WDATA,
    input  logic [STRB_WIDTH-1:0]        s_WSTRB,
    input  logic                         s_WLAST,
    input  logic                         s_WVALID,
    output logic                         s_WREADY,
    output logic [DATA_WIDTH-1:0]        m_WDATA,
    output logic [STRB_WIDTH-1:0]        m_WSTRB,
    output logic                         m_WLAST,
    output logic                         m_WVALID,
    input  logic                         m_WREADY,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         almost_full,
    output logic [$clog2(DEPTH):0]       bursts
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LEVEL);

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [STRB_WIDTH-1:0] mem_strb [DEPTH];
    logic                  mem_last [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             push_last;
    logic             pop_last;

    // Ready and valid come only from registered occupancy, so neither side sees the other combinationally.
    assign s_WREADY    = (count != DEPTH_C);
    assign almost_full = (count >= AFULL_C);

`ifdef XBAR_W_STORE_FWD_EN
    // A full buffer with no complete burst can never complete one; release anyway to avoid deadlock.
    assign m_WVALID = (bursts != '0) || ((count == DEPTH_C) && (bursts == '0));
`else
    assign m_WVALID = (count != '0);
`endif

    assign m_WDATA = mem_data[rd_ptr];
    assign m_WSTRB = mem_strb[rd_ptr];
    assign m_WLAST = mem_last[rd_ptr];

    assign push      = s_WVALID && s_WREADY;
    assign pop       = m_WVALID && m_WREADY;
    assign push_last = push && s_WLAST;
    assign pop_last  = pop && m_WLAST;

    // Payload storage is deliberately not reset.
    always_ff @(posedge ACLK) begin
        if (push && !ARESET) begin
            mem_data[wr_ptr] <= s_WDATA;
            mem_strb[wr_ptr] <= s_WSTRB;
            mem_last[wr_ptr] <= s_WLAST;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            bursts <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (push_last && !pop_last) begin
                bursts <= bursts + CNT_W'(1);
            end else if (pop_last && !push_last) begin
                bursts <= bursts - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_xbar_w_buffer.sv
// Randomized and directed bench for xbar_w_buffer against a queue-based reference model.
// Follows XBAR_W_STORE_FWD_EN in the model so either build can be checked.
module tb_xbar_w_buffer;

    localparam int DATA_WIDTH  = 32;
    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int DEPTH       = 4;
    localparam int AFULL_LEVEL = DEPTH - 1;
    localparam int CNT_W       = $clog2(DEPTH) + 1;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic                  last;
    } beat_t;

    logic                  ACLK = 1'b0;
    logic                  ARESET = 1'b1;
    logic [DATA_WIDTH-1:0] s_WDATA = '0;
    logic [STRB_WIDTH-1:0] s_WSTRB = '0;
    logic                  s_WLAST = 1'b0;
    logic                  s_WVALID = 1'b0;
    logic                  s_WREADY;
    logic [DATA_WIDTH-1:0] m_WDATA;
    logic [STRB_WIDTH-1:0] m_WSTRB;
    logic                  m_WLAST;
    logic                  m_WVALID;
    logic                  m_WREADY = 1'b0;
    logic [CNT_W-1:0]      count;
    logic                  almost_full;
    logic [CNT_W-1:0]      bursts;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t model_q[$];
    bit    last_push;

    xbar_w_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .DEPTH      (DEPTH),
        .AFULL_LEVEL(AFULL_LEVEL)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .s_WDATA    (s_WDATA),
        .s_WSTRB    (s_WSTRB),
        .s_WLAST    (s_WLAST),
        .s_WVALID   (s_WVALID),
        .s_WREADY   (s_WREADY),
        .m_WDATA    (m_WDATA),
        .m_WSTRB    (m_WSTRB),
        .m_WLAST    (m_WLAST),
        .m_WVALID   (m_WVALID),
        .m_WREADY   (m_WREADY),
        .count      (count),
        .almost_full(almost_full),
        .bursts     (bursts)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_bursts();
        int n = 0;
        foreach (model_q[i]) if (model_q[i].last) n++;
        return n;
    endfunction

    function automatic bit model_valid();
`ifdef XBAR_W_STORE_FWD_EN
        return (model_bursts() != 0) || (model_q.size() == DEPTH);
`else
        return model_q.size() != 0;
`endif
    endfunction

    task automatic check_outputs();
        bit ev;
        ev = model_valid();
        chk("count",       64'(count),       64'(model_q.size()));
        chk("s_WREADY",    64'(s_WREADY),    64'(model_q.size() != DEPTH));
        chk("m_WVALID",    64'(m_WVALID),    64'(ev));
        chk("almost_full", 64'(almost_full), 64'(model_q.size() >= AFULL_LEVEL));
        chk("bursts",      64'(bursts),      64'(model_bursts()));
        if (ev && model_q.size() != 0) begin
            chk("m_WDATA", 64'(m_WDATA), 64'(model_q[0].data));
            chk("m_WSTRB", 64'(m_WSTRB), 64'(model_q[0].strb));
            chk("m_WLAST", 64'(m_WLAST), 64'(model_q[0].last));
        end
    endtask

    // Advance one clock: model consumes the inputs held across the edge, then outputs are compared.
    task automatic cycle();
        bit    push;
        bit    pop;
        beat_t b;
        @(posedge ACLK);
        push = 1'b0;
        if (ARESET) begin
            model_q.delete();
        end else begin
            push = s_WVALID && (model_q.size() != DEPTH);
            pop  = model_valid() && m_WREADY;
            b.data = s_WDATA;
            b.strb = s_WSTRB;
            b.last = s_WLAST;
            if (pop) void'(model_q.pop_front());
            if (push) model_q.push_back(b);
        end
        last_push = push;
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [DATA_WIDTH-1:0] d, input bit l, input bit mr);
        s_WVALID = v;
        s_WDATA  = d;
        s_WSTRB  = STRB_WIDTH'(d ^ 32'h5);
        s_WLAST  = l;
        m_WREADY = mr;
    endtask

    initial begin
        int idx;
        // Reset state
        ARESET = 1'b1;
        drive(1'b1, 32'hdead, 1'b1, 1'b1);
        cycle();
        cycle();
        ARESET = 1'b0;

        // Fill with downstream stalled; fifth beat must be refused
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h10 + 32'(i), (i == 1), 1'b0);
            cycle();
        end

        // Drain the full buffer while offering A0..A3 across the pointer wrap
        idx = 0;
        for (int i = 0; i < 20 && (idx < 4 || model_q.size() != 0); i++) begin
            drive(idx < 4, 32'hA0 + 32'(idx), 1'b1, 1'b1);
            cycle();
            if (last_push) idx++;
        end
        chk("wrap_drain_pushed", 64'(idx), 64'd4);
        drive(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle();
        chk("wrap_drain_empty", 64'(count), 64'd0);

        // Steady state at occupancy 2 with simultaneous push and pop
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
            cycle();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h300 + 32'(i), 1'b1, 1'b1);
            cycle();
        end
        chk("steady_count", 64'(count), 64'd2);

        // Reset mid-burst with count 3, one complete burst stored
        ARESET = 1'b1;
        cycle();
        ARESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + 32'(i), (i == 1), 1'b0);
            cycle();
        end
        ARESET = 1'b1;
        drive(1'b1, 32'h4ff, 1'b1, 1'b1);
        cycle();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_bursts", 64'(bursts), 64'd0);
        ARESET = 1'b0;

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) != 0);
            ARESET = ($urandom_range(0, 99) == 0);
            cycle();
        end
        ARESET = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xbar_w_buffer.md
XBAR_W_BUFFER -- requirements
Module: xbar_w_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: W data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter STRB_WIDTH, default DATA_WIDTH/8: byte-strobe width.
REQ-003 Parameter DEPTH, default 4: entry count; SHALL be a power of two, >= 2.
REQ-004 Parameter AFULL_LEVEL, default DEPTH-1: occupancy at which almost_full asserts; range 1..DEPTH.
REQ-005 ACLK  in  1  sole clock; all state updates on the rising edge.
REQ-006 ARESET  in  1  reset; synchronous and active-high.
REQ-007 s_WDATA  in  DATA_WIDTH  write data from the upstream master.
REQ-008 s_WSTRB  in  STRB_WIDTH  write strobes from the upstream master.
REQ-009 s_WLAST  in  1  last beat of the burst.
REQ-010 s_WVALID  in  1  upstream beat valid.
REQ-011 s_WREADY  out  1  buffer can accept a beat.
REQ-012 m_WDATA, m_WSTRB, m_WLAST  out  DATA_WIDTH / STRB_WIDTH / 1  head-entry contents.
REQ-013 m_WVALID  out  1  head beat presentable downstream.
REQ-014 m_WREADY  in  1  downstream accepts the head beat.
REQ-015 count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 almost_full  out  1  count >= AFULL_LEVEL.
REQ-017 bursts  out  $clog2(DEPTH)+1  number of stored beats with WLAST=1.

Function
REQ-018 Push SHALL occur iff s_WVALID && s_WREADY; pop SHALL occur iff m_WVALID && m_WREADY.
REQ-019 s_WREADY SHALL equal (count != DEPTH); all DEPTH entries SHALL be usable.
REQ-020 A push SHALL write {WDATA, WSTRB, WLAST} at the write pointer and advance it by 1 modulo DEPTH.
REQ-021 A pop SHALL advance the read pointer by 1 modulo DEPTH; pointers SHALL wrap with no lost or duplicated entry.
REQ-022 m_WDATA/m_WSTRB/m_WLAST SHALL be driven combinationally from the read-pointer entry; they are don't-care while m_WVALID=0.
REQ-023 Latency: a beat pushed at edge N SHALL be visible on m_* with m_WVALID=1 from the cycle after edge N (subject to REQ-036), with no combinational path from s_* to m_*.
REQ-024 count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-025 Simultaneous push and pop while full SHALL NOT occur, because s_WREADY=0 when full.
REQ-026 Simultaneous push and pop while empty SHALL NOT occur, because m_WVALID=0 when empty.
REQ-027 bursts SHALL increment on a push with s_WLAST=1 and decrement on a pop with m_WLAST=1; when both happen in one cycle it SHALL hold.
REQ-028 s_WREADY SHALL NOT depend combinationally on m_WREADY.
REQ-029 Once asserted, m_WVALID SHALL NOT deassert until its beat is popped.
REQ-030 A beat offered while s_WREADY=0 SHALL NOT be stored.
REQ-031 Payload is not checked; s_WVALID and m_WREADY drive push and pop regardless of content.

Reset
REQ-032 While ARESET=1 at a rising edge: pointers, count and bursts SHALL be 0.
REQ-033 During and after reset: s_WREADY=1, m_WVALID=0, almost_full=0 (AFULL_LEVEL >= 1).
REQ-034 Entry storage SHALL NOT be reset; m_WDATA/m_WSTRB/m_WLAST are unspecified while m_WVALID=0.
REQ-035 Reset asserted mid-burst SHALL discard all stored beats and partial bursts; push and pop SHALL be ignored in the reset cycle.

Configuration
REQ-036 Macro XBAR_W_STORE_FWD_EN defined: m_WVALID SHALL equal (bursts != 0), so beats release only once their complete burst is buffered.
REQ-037 With XBAR_W_STORE_FWD_EN defined: if count == DEPTH and bursts == 0, m_WVALID SHALL be forced to 1 to avoid deadlock on bursts longer than DEPTH.
REQ-038 Macro XBAR_W_STORE_FWD_EN undefined: m_WVALID SHALL equal (count != 0) (cut-through); bursts SHALL still be maintained.

Verification
REQ-039 DEPTH=4: push 4 beats with m_WREADY=0 -> count=4, s_WREADY=0, almost_full=1 from count=3; a 5th offered beat is not stored.
REQ-040 Fill to 4, then pop 4 while pushing 0xA0..0xA3 -> m_WDATA order exact across pointer wrap, count returns to 0.
REQ-041 count=2, s_WVALID=m_WVALID=m_WREADY=1 for 10 cycles -> count stays 2, output stream equals input stream delayed by 2 beats.
REQ-042 Store-forward defined: push beats 0x1,0x2 (WLAST=0) then 0x3 (WLAST=1) -> m_WVALID=0 until the cycle after the 0x3 push, then bursts=1.
REQ-043 Store-forward defined, DEPTH=4: push 4 beats with WLAST=0 -> m_WVALID=1 via the REQ-037 override, drain completes.
REQ-044 Assert ARESET with count=3, bursts=1 -> next cycle count=0, bursts=0, m_WVALID=0, s_WREADY=1.
